// File: rtl/integ_m256_n1_pkg.sv
// Shared constants, FSM encoding and pipeline beat type for the multi-channel integrator.
package integ_m256_n1_pkg;

  localparam int unsigned DATA_WIDTH    = 48;
  localparam int unsigned ADDR_WIDTH    = 8;
  localparam int unsigned K_WIDTH       = ADDR_WIDTH + 1;
  localparam int unsigned NUM_CHAN      = 2 ** ADDR_WIDTH;
  localparam int unsigned INTEG_LATENCY = 4;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } integ_state_e;

  // One sample travelling down the read-add-write pipeline.
  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] chan;
    logic [DATA_WIDTH-1:0] data;
  } integ_beat_t;

  // A channel count of 0 behaves as a single channel.
  function automatic logic [K_WIDTH-1:0] map_k(input logic [K_WIDTH-1:0] m);
    return (m == '0) ? K_WIDTH'(1) : m;
  endfunction

endpackage

// File: rtl/integ_state_ram.sv
// Per-channel accumulator storage: simple dual-port RAM, registered read, old data on read-during-write.
module integ_state_ram
  import integ_m256_n1_pkg::*;
(
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [NUM_CHAN];

  // Write port and one-cycle registered read port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/integ_m256_n1.sv
// Multi-channel CIC integrator: y_k[n] = y_k[n-1] + x_k[n] over K time-interleaved channels.
module integ_m256_n1
  import integ_m256_n1_pkg::*;
(
  input  logic                  clk,
  input  logic                  sync_reset,
  input  logic [K_WIDTH-1:0]    msetting,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  s_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [ADDR_WIDTH-1:0] m_axis_tuser
);

  integ_state_e          state;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [ADDR_WIDTH-1:0] chan;
  logic [K_WIDTH-1:0]    k_r;
  logic [K_WIDTH-1:0]    k_in_c;
  logic                  k_change_c;
  logic                  accept_c;
  logic                  flush_c;

  integ_beat_t           s1, s2, s3, s4;
  logic [DATA_WIDTH-1:0] base2;
  logic [DATA_WIDTH-1:0] sum2_c;
  logic [DATA_WIDTH-1:0] base_c;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  ram_we_c;
  logic [ADDR_WIDTH-1:0] ram_waddr_c;
  logic [DATA_WIDTH-1:0] ram_wdata_c;

  assign k_in_c     = map_k(msetting);
  assign k_change_c = (state == ST_RUN) && (k_in_c != k_r);
  assign accept_c   = s_axis_tvalid && s_axis_tready && !k_change_c;
  assign flush_c    = sync_reset || k_change_c;

  // Control FSM: RAM clear sweep, channel count latch, channel counter.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state         <= ST_CLEAR;
      clr_addr      <= '0;
      chan          <= '0;
      k_r           <= K_WIDTH'(1);
      s_axis_tready <= 1'b0;
    end else if (state == ST_CLEAR) begin
      clr_addr <= clr_addr + ADDR_WIDTH'(1);
      if (clr_addr == ADDR_WIDTH'(NUM_CHAN - 1)) begin
        k_r           <= k_in_c;
        state         <= ST_RUN;
        s_axis_tready <= 1'b1;
      end
    end else begin
      if (k_change_c) begin
        state         <= ST_CLEAR;
        clr_addr      <= '0;
        chan          <= '0;
        s_axis_tready <= 1'b0;
      end else if (accept_c) begin
        chan <= ({1'b0, chan} == k_r - K_WIDTH'(1)) ? '0 : chan + ADDR_WIDTH'(1);
      end
    end
  end

  // Newest in-flight sum for the channel wins over the RAM copy; stage 4 covers same-edge write/read.
  assign sum2_c = base2 + s2.data;
  always_comb begin
    base_c = ram_q;
    if (s4.valid && s4.chan == s1.chan) base_c = s4.data;
    if (s3.valid && s3.chan == s1.chan) base_c = s3.data;
    if (s2.valid && s2.chan == s1.chan) base_c = sum2_c;
  end

  // Datapath: accept -> read -> operand -> sum/write -> hold -> output (4 cycles).
  always_ff @(posedge clk) begin
    if (flush_c) begin
      s1            <= '0;
      s2            <= '0;
      base2         <= '0;
      s3            <= '0;
      s4            <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
    end else begin
      s1            <= '{valid: accept_c, chan: chan, data: s_axis_tdata};
      s2            <= s1;
      base2         <= base_c;
      s3            <= '{valid: s2.valid, chan: s2.chan, data: sum2_c};
      s4            <= s3;
      m_axis_tvalid <= s4.valid;
      if (s4.valid) begin
        m_axis_tdata <= s4.data;
        m_axis_tuser <= s4.chan;
      end
    end
  end

  // RAM write source: zero sweep while clearing, otherwise the freshly computed sum.
  always_comb begin
    ram_we_c    = s3.valid;
    ram_waddr_c = s3.chan;
    ram_wdata_c = s3.data;
    if (state == ST_CLEAR) begin
      ram_we_c    = 1'b1;
      ram_waddr_c = clr_addr;
      ram_wdata_c = '0;
    end
  end

  integ_state_ram u_ram (
    .clk   (clk),
    .we    (ram_we_c),
    .waddr (ram_waddr_c),
    .wdata (ram_wdata_c),
    .raddr (chan),
    .rdata (ram_q)
  );

endmodule
